// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type, SPI mode encodings, synchroniser depths.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // SPI mode encoding {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned SYNC_STAGES_CTRL = 3;
  localparam int unsigned SYNC_STAGES_DATA = 2;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_frame_slave_if.sv
// SPI bus bundle (SCK, SSEL active-low, MOSI, MISO).
//   master modport: drives SCK/SSEL/MOSI, receives MISO
//   slave  modport: receives SCK/SSEL/MOSI, drives MISO
interface spi_frame_slave_if;
  logic SCK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  modport master (output SCK, output SSEL, output MOSI, input MISO);
  modport slave  (input SCK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_edge_sync.sv
// Shift-register synchroniser for one asynchronous input with edge detection.
//   din   : asynchronous input
//   level : synchronised level (stage 1)
//   rise  : one-cycle pulse on a 0->1 transition seen on stages [2:1]
//   fall  : one-cycle pulse on a 1->0 transition seen on stages [2:1]
// With DEPTH=2 only the level is meaningful; rise/fall are tied low.
module spi_edge_sync #(
  parameter int unsigned DEPTH   = 3,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[DEPTH-2:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {DEPTH{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign level = sync_q[1];

  if (DEPTH >= 3) begin : g_edge
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave with fixed-length frames, TX holding register and RX word output.
// Optional feature macro: SPI_FRAME_ERR_EN adds the frame_err pulse output
// (partial frame aborted by SSEL, or TX underrun at a frame boundary).
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   spi                 : SPI bus (slave modport)
//   tx_data/valid/ready : TX holding-register handshake
//   rx_data, rx_valid   : last complete frame, one-cycle update pulse
//   busy                : high while a frame session is active
//   frame_err           : (SPI_FRAME_ERR_EN only) one-cycle error pulse
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W   = 88,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_frame_slave_if.slave   spi,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  localparam int unsigned CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [1:0] MODE = spi_mode(CPOL, CPHA);
  localparam bit LEAD_FALL   = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
  localparam bit SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  // Synchronisers
  logic sck_rise, sck_fall, ssel_rise, ssel_fall, mosi_s;
  logic unused_sck_level, unused_ssel_level, unused_mosi_rise, unused_mosi_fall;

  spi_edge_sync #(.DEPTH(SYNC_STAGES_CTRL), .RST_VAL(CPOL)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(spi.SCK),
    .level(unused_sck_level), .rise(sck_rise), .fall(sck_fall));

  spi_edge_sync #(.DEPTH(SYNC_STAGES_CTRL), .RST_VAL(1'b1)) u_ssel (
    .clk(clk), .rst_n(rst_n), .din(spi.SSEL),
    .level(unused_ssel_level), .rise(ssel_rise), .fall(ssel_fall));

  spi_edge_sync #(.DEPTH(SYNC_STAGES_DATA), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi.MOSI),
    .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = LEAD_FALL ? sck_fall : sck_rise;
  assign trail_edge  = LEAD_FALL ? sck_rise : sck_fall;
  assign sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
  assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

  function automatic logic first_bit(input logic [FRAME_W-1:0] w);
    return MSB_FIRST ? w[FRAME_W-1] : w[0];
  endfunction

  function automatic logic [FRAME_W-1:0] drop_bit(input logic [FRAME_W-1:0] w);
    return MSB_FIRST ? {w[FRAME_W-2:0], 1'b0} : {1'b0, w[FRAME_W-1:1]};
  endfunction

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d, hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               boundary, handshake;
  logic [FRAME_W-1:0] rx_next, next_word;

  assign handshake = tx_valid & ~hold_full_q;
  assign rx_next   = MSB_FIRST ? {rx_sh_q[FRAME_W-2:0], mosi_s}
                               : {mosi_s, rx_sh_q[FRAME_W-1:1]};

  // Next-state: session FSM, bit counter, RX/TX shifting, holding register
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    boundary    = 1'b0;
    next_word   = '0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ssel_fall) begin
          state_d  = ACTIVE;
          bitcnt_d = '0;
          boundary = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          miso_d   = 1'b0;
        end else if (sample_edge) begin
          rx_sh_d = rx_next;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d   = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            boundary   = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else if (shift_edge && (!SAMPLE_LEAD || bitcnt_q != '0)) begin
          // With CPHA=0 the trailing edge right after a wrap must not
          // advance: the new frame's first bit is already on MISO.
          miso_d  = first_bit(tx_sh_q);
          tx_sh_d = drop_bit(tx_sh_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame boundary: holding register (or bypassed tx_data, or zeros) to TX shifter
    if (boundary) begin
      next_word   = hold_full_q ? hold_q : (handshake ? tx_data : '0);
      hold_full_d = 1'b0;
      if (SAMPLE_LEAD) begin
        miso_d  = first_bit(next_word);
        tx_sh_d = drop_bit(next_word);
      end else begin
        tx_sh_d = next_word;
      end
    end else if (handshake) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  // Error pulse: partial frame aborted, or boundary with nothing to send
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = 1'b0;
    if ((state_q == ACTIVE) && ssel_rise && (bitcnt_q != '0)) frame_err_d = 1'b1;
    if (boundary && !hold_full_q && !handshake)                frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

  assign spi.MISO = miso_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);

endmodule
